fifo_core: RTL and testbench
============================

// Module: fifo_core
// PURPOSE
//  Synchronous FIFO storage stage directly downstream of the fifo_in agent's pin bundle.
//  Accepts 32-bit words on a valid/ready input handshake and buffers up to DEPTH entries.
//  Presents them first-word-fall-through on a valid/ready output handshake.
//  This is the DUT driven by the fifo_in UVM environment; the output side feeds the downstream consumer/monitor.
// PARAMETERS
//  DATA_W     32  width of data_in / data_out
//  DEPTH      16  number of entries; power of two, >= 2
//  AFULL_THR  12  almost_full asserts when fill_level >= AFULL_THR; 1..DEPTH
// PORTS
//  clk           in   1                 single clock; all state updates on posedge
//  rst_n         in   1                 asynchronous, active-low reset
//  data_in       in   DATA_W            write data, sampled when data_in_vld && data_in_rdy
//  data_in_vld   in   1                 upstream offers a word
//  data_in_rdy   out  1                 FIFO can accept a word (not full)
//  data_out      out  DATA_W            head-of-queue word; 0 when data_out_vld == 0
//  data_out_vld  out  1                 FIFO holds at least one word (not empty)
//  data_out_rdy  in   1                 downstream takes head word when data_out_vld && data_out_rdy
//  fill_level    out  $clog2(DEPTH)+1   current number of stored entries, 0..DEPTH
//  almost_full   out  1                 fill_level >= AFULL_THR
// BEHAVIOUR
//  Reset:
//   - rst_n low clears wr_ptr, rd_ptr and fill_level asynchronously.
//   - While rst_n is low: data_in_rdy = 0, data_out_vld = 0, data_out = 0, fill_level = 0, almost_full = 0.
//   - Memory array is not reset.
//   - After release, data_in_rdy = 1 from the first cycle.
//   - Reset mid-operation discards all contents; no partial handshakes survive.
//  Storage:
//   - DEPTH x DATA_W array.
//   - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits; the MSB is a wrap flag.
//   - empty = (wr_ptr == rd_ptr); full = addresses equal and wrap flags differ.
//   - Pointers wrap naturally from DEPTH-1 to 0 with the flag toggling.
//  Handshakes:
//   - push = data_in_vld && data_in_rdy, with data_in_rdy = !full.
//   - pop = data_out_vld && data_out_rdy, with data_out_vld = !empty.
//   - data_in_rdy and data_out_vld depend only on registered state.
//   - There is no combinational path from data_in_vld to data_out_* or from data_out_rdy to data_in_rdy.
//   - Upstream may hold data_in_vld while data_in_rdy = 0; nothing is written and nothing is lost.
//   - Downstream stall: while data_out_vld && !data_out_rdy, data_out stays stable.
//  Latency:
//   - A word pushed at edge N appears on data_out with data_out_vld = 1 after edge N, if the FIFO was empty.
//   - No same-cycle bypass: an empty FIFO never shows data_out_vld in the cycle data_in_vld first rises.
//   - A pop at edge N advances the head after edge N.
//  Simultaneous push and pop:
//   - Both take effect; fill_level is unchanged.
//   - When full, push cannot occur (data_in_rdy = 0); a pop frees one slot and data_in_rdy = 1 next cycle.
//   - When empty, pop cannot occur; a push makes data_out_vld = 1 next cycle.
//  fill_level / almost_full:
//   - fill_level = fill_level + push - pop, registered.
//   - almost_full is registered, derived from the next fill_level, so it is coherent with fill_level each cycle.
//  Ordering: strict FIFO order; no reordering and no duplication.
// TESTING
//  1 Reset/idle:
//     - Stimulus: hold rst_n low 5 cycles, release.
//     - Response: data_in_rdy = 1, data_out_vld = 0, data_out = 0, fill_level = 0 in the first post-reset cycle.
//  2 Single word:
//     - Stimulus: push 0xDEADBEEF with data_out_rdy = 0.
//     - Response: next cycle data_out_vld = 1, data_out = 0xDEADBEEF, fill_level = 1, stable for 10 stall cycles.
//     - Then assert data_out_rdy for 1 cycle -> data_out_vld = 0.
//  3 Fill to full:
//     - Stimulus: push 16 words 0..15 with data_out_rdy = 0.
//     - Response: almost_full rises after the 12th push; data_in_rdy = 0 with fill_level = 16.
//     - A held 17th word 0xAA is not written; draining yields 0..15 in order, then 0xAA.
//  4 Full with simultaneous push and pop:
//     - Stimulus: at full, data_out_rdy = 1 for 1 cycle with data_in_vld held.
//     - Response: fill_level 16 -> 15 -> 16; no word accepted during the full cycle.
//  5 Wrap-around streaming:
//     - Stimulus: continuous push and pop of 100 incrementing words with random vld/rdy gaps (seeded).
//     - Response: output sequence equals input sequence; fill_level never exceeds 16 and never goes below 0.
//  6 Reset mid-stream:
//     - Stimulus: assert rst_n low asynchronously (off-edge) with fill_level = 7.
//     - Response: outputs go to reset values immediately.
//     - After release, the first pushed word 0x1234 is the first word out.

Source files
------------

// File: rtl/fifo_core.sv
// First-word-fall-through synchronous FIFO with valid/ready handshakes on both sides.
// The MSB of each pointer is a wrap flag, so full and empty come straight from the pointers.
module fifo_core #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 16,
   parameter int AFULL_THR = 12
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DATA_W-1:0]          data_in,
   input  logic                       data_in_vld,
   output logic                       data_in_rdy,
   output logic [DATA_W-1:0]          data_out,
   output logic                       data_out_vld,
   input  logic                       data_out_rdy,
   output logic [$clog2(DEPTH):0]     fill_level,
   output logic                       almost_full
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr_reg;
   logic [PW-1:0]     rd_ptr_reg;
   logic [PW-1:0]     fill_reg;
   logic [PW-1:0]     fill_next;
   logic              afull_reg;
   logic              empty;
   logic              full;
   logic              push;
   logic              pop;

   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                  (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

   // Held low while reset is asserted so upstream never sees a ready during reset.
   assign data_in_rdy  = rst_n && !full;
   assign data_out_vld = !empty;
   assign data_out     = data_out_vld ? mem[rd_ptr_reg[AW-1:0]] : '0;

   assign push = data_in_vld && data_in_rdy;
   assign pop  = data_out_vld && data_out_rdy;

   always_comb begin
      fill_next = fill_reg;
      if (push && !pop) begin
         fill_next = fill_reg + PW'(1);
      end else if (pop && !push) begin
         fill_next = fill_reg - PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg[AW-1:0]] <= data_in;
      end
   end

   // almost_full tracks the next fill level so both flip together on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         fill_reg   <= '0;
         afull_reg  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         fill_reg  <= fill_next;
         afull_reg <= (fill_next >= PW'(AFULL_THR));
      end
   end

   assign fill_level  = fill_reg;
   assign almost_full = afull_reg;

endmodule

// File: tb/tb_fifo_core.sv
// Randomised bench for fifo_core, checked against a queue-based model of the FIFO.
module tb_fifo_core;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int AFULL  = 12;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [DATA_W-1:0] data_in;
   logic              data_in_vld;
   logic              data_in_rdy;
   logic [DATA_W-1:0] data_out;
   logic              data_out_vld;
   logic              data_out_rdy;
   logic [4:0]        fill_level;
   logic              almost_full;

   int total = 0;
   int bad   = 0;
   logic [31:0] model_q[$];

   fifo_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_THR(AFULL)) dut (
      .clk(clk), .rst_n(rst_n),
      .data_in(data_in), .data_in_vld(data_in_vld), .data_in_rdy(data_in_rdy),
      .data_out(data_out), .data_out_vld(data_out_vld), .data_out_rdy(data_out_rdy),
      .fill_level(fill_level), .almost_full(almost_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      int n;
      n = model_q.size();
      chk("in_rdy",   32'(data_in_rdy),  32'(n < DEPTH));
      chk("out_vld",  32'(data_out_vld), 32'(n > 0));
      chk("out_data", data_out,          (n > 0) ? model_q[0] : 32'h0);
      chk("fill",     32'(fill_level),   32'(n));
      chk("afull",    32'(almost_full),  32'(n >= AFULL));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rdy"},  32'(data_in_rdy),  32'h0);
      chk({tag, "_vld"},  32'(data_out_vld), 32'h0);
      chk({tag, "_data"}, data_out,          32'h0);
      chk({tag, "_fill"}, 32'(fill_level),   32'h0);
      chk({tag, "_af"},   32'(almost_full),  32'h0);
   endtask

   // One clock: drive at +1 after the edge, update the model at the edge, check at +1.
   task automatic cycle(input logic vld, input logic [31:0] d, input logic rdy,
                        output logic pushed, output logic popped, output logic [31:0] pword);
      data_in_vld  = vld;
      data_in      = d;
      data_out_rdy = rdy;
      pushed = vld && (model_q.size() < DEPTH);
      popped = rdy && (model_q.size() > 0);
      pword  = (model_q.size() > 0) ? model_q[0] : 32'h0;
      if (popped) chk("pop_word", data_out, pword);
      @(posedge clk);
      if (popped) void'(model_q.pop_front());
      if (pushed) model_q.push_back(d);
      #1;
      if (pushed || popped)
         $display("t=%0t push=%0b din=%h pop=%0b dout=%h fill=%0d",
                  $time, pushed, d, popped, pword, model_q.size());
      check_state();
   endtask

   initial begin
      logic pu, po;
      logic [31:0] pw;
      int sent, recv, guard;

      void'($urandom(32'd20240611));
      rst_n = 1'b0;
      data_in = 32'h5555_5555;
      data_in_vld = 1'b1;
      data_out_rdy = 1'b1;

      // 1: reset held 5 cycles, upstream offering the whole time
      repeat (5) begin
         @(posedge clk);
         #1;
         check_reset_outputs("reset_hold");
      end
      data_in_vld = 1'b0;
      data_out_rdy = 1'b0;
      rst_n = 1'b1;
      #1;
      check_state();
      chk("post_reset_rdy", 32'(data_in_rdy), 32'h1);

      // 2: single word, stall 10 cycles, then pop
      cycle(1'b1, 32'hDEAD_BEEF, 1'b0, pu, po, pw);
      chk("single_fill", 32'(fill_level), 32'h1);
      repeat (10) begin
         cycle(1'b0, 32'h0, 1'b0, pu, po, pw);
         chk("single_stable", data_out, 32'hDEAD_BEEF);
      end
      cycle(1'b0, 32'h0, 1'b1, pu, po, pw);
      chk("single_popped_vld", 32'(data_out_vld), 32'h0);

      // 3: fill to full, then hold a 17th word
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b1, 32'(i), 1'b0, pu, po, pw);
         if (i == AFULL - 2) chk("af_before_thr", 32'(almost_full), 32'h0);
         if (i == AFULL - 1) chk("af_at_thr", 32'(almost_full), 32'h1);
      end
      chk("full_fill", 32'(fill_level), 32'd16);
      chk("full_rdy", 32'(data_in_rdy), 32'h0);
      repeat (3) cycle(1'b1, 32'hAA, 1'b0, pu, po, pw);
      chk("full_held_fill", 32'(fill_level), 32'd16);

      // 4: pop once while full with push held; slot refills next cycle
      cycle(1'b1, 32'hAA, 1'b1, pu, po, pw);
      chk("full_pop_fill", 32'(fill_level), 32'd15);
      cycle(1'b1, 32'hAA, 1'b0, pu, po, pw);
      chk("refill_fill", 32'(fill_level), 32'd16);
      for (int i = 1; i < DEPTH; i++) begin
         cycle(1'b0, 32'h0, 1'b1, pu, po, pw);
         chk("drain_order", pw, 32'(i));
      end
      cycle(1'b0, 32'h0, 1'b1, pu, po, pw);
      chk("drain_last", pw, 32'hAA);
      chk("drain_empty", 32'(data_out_vld), 32'h0);

      // 5: random-gap streaming of 100 incrementing words
      sent = 0;
      recv = 0;
      guard = 0;
      while ((sent < 100 || model_q.size() > 0) && guard < 5000) begin
         cycle((sent < 100) && ($urandom_range(0, 3) != 0), 32'(sent + 100),
               $urandom_range(0, 2) != 0, pu, po, pw);
         if (pu) sent++;
         if (po) begin
            chk("stream_order", pw, 32'(recv + 100));
            recv++;
         end
         chk("stream_fill_max", 32'(fill_level <= 5'd16), 32'h1);
         guard++;
      end
      chk("stream_count", 32'(recv), 32'd100);

      // 6: asynchronous reset with 7 words stored
      for (int i = 0; i < 7; i++) cycle(1'b1, 32'hC000 + 32'(i), 1'b0, pu, po, pw);
      chk("pre_reset_fill", 32'(fill_level), 32'd7);
      data_in_vld = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      model_q.delete();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("async_hold");
      rst_n = 1'b1;
      #1;
      check_state();
      cycle(1'b1, 32'h1234, 1'b0, pu, po, pw);
      chk("after_reset_head", data_out, 32'h1234);
      cycle(1'b0, 32'h0, 1'b1, pu, po, pw);
      chk("after_reset_pop", pw, 32'h1234);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
